// File: rtl/stress_acc_pkg.sv
// Shared types and constants for the stress decision-fusion stage.
package stress_acc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2,
    HOLD    = 2'd3
  } fuse_state_t;

  localparam logic [1:0] MODE_OR   = 2'd0;
  localparam logic [1:0] MODE_AND  = 2'd1;
  localparam logic [1:0] MODE_KOFN = 2'd2;

endpackage

// File: rtl/stress_popcount.sv
// Combinational population count of an N-bit vector.
module stress_popcount #(
  parameter int N = 2,
  localparam int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  bits,
  output logic [CW-1:0] count
);

  // Sum the set bits; CW is wide enough to hold N without overflow.
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/stress_vote_combiner.sv
// Fuses done/stress results of N_CH classifier cores into one registered
// decision (OR, AND or K-of-N vote) with a per-run timeout.
module stress_vote_combiner
  import stress_acc_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int TW   = 16,
  localparam int CNTW = $clog2(N_CH + 1)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [N_CH-1:0] ch_start,
  input  logic [N_CH-1:0] ch_done,
  input  logic [N_CH-1:0] ch_stress,
  input  logic [1:0]      mode,
  input  logic [CNTW-1:0] vote_k,
  input  logic [TW-1:0]   timeout_cycles,
  output logic            valid,
  output logic            stress_out,
  output logic            timeout,
  output logic [CNTW-1:0] stress_count,
  output logic [N_CH-1:0] done_mask
);

  fuse_state_t     state;
  logic [N_CH-1:0] act_mask;
  logic [N_CH-1:0] done_l;
  logic [N_CH-1:0] stress_l;
  logic [TW-1:0]   timer;
  logic            timeout_en;
  logic            to_flag;
  logic [CNTW-1:0] k_reg;
  logic [1:0]      mode_reg;

  logic [N_CH-1:0] acc_done;
  logic [N_CH-1:0] first_done;
  logic [N_CH-1:0] done_next;
  logic [N_CH-1:0] stress_next;
  logic            all_done;
  logic [N_CH-1:0] hit_mask;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] act_cnt;
  logic [CNTW-1:0] k_eff;
  logic            fused;

  assign hit_mask = stress_l & done_l;

  stress_popcount #(.N(N_CH)) u_hit_cnt (
    .bits  (hit_mask),
    .count (cnt)
  );

  stress_popcount #(.N(N_CH)) u_act_cnt (
    .bits  (act_mask),
    .count (act_cnt)
  );

  // Next latch contents: only the first done pulse of an active channel captures its stress bit.
  always_comb begin
    acc_done    = ch_done & act_mask;
    first_done  = acc_done & ~done_l;
    done_next   = done_l | acc_done;
    stress_next = (stress_l & ~first_done) | (ch_stress & first_done);
    all_done    = (done_next == act_mask);
  end

  // Fusion rule selected at run start; reserved mode falls back to OR, K of zero acts as one.
  always_comb begin
    k_eff = (k_reg == '0) ? CNTW'(1) : k_reg;
    case (mode_reg)
      MODE_AND:  fused = (cnt == act_cnt) && !to_flag;
      MODE_KOFN: fused = (cnt >= k_eff);
      default:   fused = (cnt != '0);
    endcase
  end

  // Run control FSM with latches, timeout timer and registered decision outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      act_mask     <= '0;
      done_l       <= '0;
      stress_l     <= '0;
      timer        <= '0;
      timeout_en   <= 1'b0;
      to_flag      <= 1'b0;
      k_reg        <= '0;
      mode_reg     <= MODE_OR;
      valid        <= 1'b0;
      stress_out   <= 1'b0;
      timeout      <= 1'b0;
      stress_count <= '0;
      done_mask    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ch_start != '0) begin
            act_mask   <= ch_start;
            done_l     <= '0;
            stress_l   <= '0;
            timer      <= timeout_cycles;
            timeout_en <= (timeout_cycles != '0);
            to_flag    <= 1'b0;
            k_reg      <= vote_k;
            mode_reg   <= mode;
            state      <= COLLECT;
          end
        end
        COLLECT: begin
          if (ch_start == '0) begin
            act_mask <= '0;
            done_l   <= '0;
            stress_l <= '0;
            state    <= IDLE;
          end else begin
            done_l   <= done_next;
            stress_l <= stress_next;
            if (all_done) begin
              to_flag <= 1'b0;
              state   <= DECIDE;
            end else if (timer == '0) begin
              if (timeout_en) begin
                to_flag <= 1'b1;
                state   <= DECIDE;
              end
            end else begin
              timer <= timer - TW'(1);
            end
          end
        end
        DECIDE: begin
          valid        <= 1'b1;
          stress_out   <= fused;
          timeout      <= to_flag;
          stress_count <= cnt;
          done_mask    <= done_l;
          state        <= HOLD;
        end
        HOLD: begin
          if (ch_start == '0) begin
            valid        <= 1'b0;
            stress_out   <= 1'b0;
            timeout      <= 1'b0;
            stress_count <= '0;
            done_mask    <= '0;
            act_mask     <= '0;
            done_l       <= '0;
            stress_l     <= '0;
            to_flag      <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stress_vote_combiner.sv
// Self-checking bench for stress_vote_combiner: directed spec scenarios plus
// randomized runs checked against a run-level reference model.
module tb_stress_vote_combiner;

  localparam int N  = 4;
  localparam int TW = 16;
  localparam int CW = 3;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [N-1:0]  ch_start;
  logic [N-1:0]  ch_done;
  logic [N-1:0]  ch_stress;
  logic [1:0]    mode;
  logic [CW-1:0] vote_k;
  logic [TW-1:0] timeout_cycles;
  logic          valid;
  logic          stress_out;
  logic          timeout;
  logic [CW-1:0] stress_count;
  logic [N-1:0]  done_mask;

  stress_vote_combiner #(.N_CH(N), .TW(TW)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .ch_start       (ch_start),
    .ch_done        (ch_done),
    .ch_stress      (ch_stress),
    .mode           (mode),
    .vote_k         (vote_k),
    .timeout_cycles (timeout_cycles),
    .valid          (valid),
    .stress_out     (stress_out),
    .timeout        (timeout),
    .stress_count   (stress_count),
    .done_mask      (done_mask)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Run configuration: per-channel first-done cycle (-1 never), first stress value, duplicate pulse cycle.
  int         cfgDoneAt[N];
  bit         cfgStress[N];
  int         cfgDupAt[N];
  logic [N-1:0] cfgAct;
  int         cfgMode;
  int         cfgK;
  int         cfgT;
  bit         cfgResetInHold;

  // Model results for the current run.
  int           expF;
  bit           expTo;
  logic [N-1:0] expMask;
  int           expCnt;
  bit           expStress;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_valid"}, valid, 0);
    checkOutput({tag, "_stress"}, stress_out, 0);
    checkOutput({tag, "_timeout"}, timeout, 0);
    checkOutput({tag, "_count"}, stress_count, 0);
    checkOutput({tag, "_mask"}, done_mask, 0);
  endtask

  // Run-level reference: decision cycle is the last active done, unless the timeout window (cycles 0..T) ends first.
  task automatic modelRun();
    int last;
    bit all;
    int actCnt;
    int k;
    last = -1;
    all  = 1;
    for (int i = 0; i < N; i++) begin
      if (cfgAct[i]) begin
        if (cfgDoneAt[i] < 0) all = 0;
        else if (cfgDoneAt[i] > last) last = cfgDoneAt[i];
      end
    end
    if (all && (cfgT == 0 || last <= cfgT)) begin
      expF  = last;
      expTo = 0;
    end else begin
      expF  = cfgT;
      expTo = 1;
    end
    expMask = '0;
    expCnt  = 0;
    actCnt  = 0;
    for (int i = 0; i < N; i++) begin
      if (cfgAct[i]) begin
        actCnt++;
        if (cfgDoneAt[i] >= 0 && cfgDoneAt[i] <= expF) begin
          expMask[i] = 1'b1;
          if (cfgStress[i]) expCnt++;
        end
      end
    end
    case (cfgMode)
      1: expStress = (expCnt == actCnt) && !expTo;
      2: begin
        k = (cfgK < 1) ? 1 : cfgK;
        expStress = (expCnt >= k);
      end
      default: expStress = (expCnt >= 1);
    endcase
  endtask

  task automatic applyStimulus(input string tag);
    logic saveStress;
    modelRun();
    ch_start       = cfgAct;
    mode           = 2'(cfgMode);
    vote_k         = CW'(cfgK);
    timeout_cycles = TW'(cfgT);
    ch_done        = '0;
    ch_stress      = 4'($urandom);
    tick();
    // Config inputs are only sampled at run start; scramble them afterwards.
    mode           = 2'($urandom);
    vote_k         = CW'($urandom);
    timeout_cycles = TW'($urandom);
    for (int c = 0; c <= expF + 1; c++) begin
      for (int i = 0; i < N; i++) begin
        if (cfgAct[i]) begin
          ch_done[i]   = (c == cfgDoneAt[i]) || (c == cfgDupAt[i]);
          ch_stress[i] = (c == cfgDoneAt[i]) ? cfgStress[i] : ~cfgStress[i];
        end else begin
          ch_done[i]   = 1'($urandom);
          ch_stress[i] = 1'($urandom);
        end
      end
      ch_start = 4'($urandom_range(1, 15));
      tick();
      checkOutput({tag, "_valid_timing"}, valid, (c == expF + 1) ? 1 : 0);
    end
    checkOutput({tag, "_stress"}, stress_out, expStress);
    checkOutput({tag, "_timeout"}, timeout, expTo);
    checkOutput({tag, "_count"}, stress_count, expCnt);
    checkOutput({tag, "_mask"}, done_mask, expMask);
    saveStress = stress_out;
    for (int h = 0; h < 2; h++) begin
      ch_done   = 4'($urandom);
      ch_stress = 4'($urandom);
      ch_start  = 4'($urandom_range(1, 15));
      tick();
      checkOutput({tag, "_hold_valid"}, valid, 1);
      checkOutput({tag, "_hold_stress"}, stress_out, expStress);
    end
    ch_done = '0;
    if (cfgResetInHold) begin
      RESET = 1'b1;
      tick();
      checkIdleOutputs({tag, "_reset"});
      RESET    = 1'b0;
      ch_start = '0;
      tick();
      checkOutput({tag, "_post_reset_valid"}, valid, 0);
    end else begin
      ch_start = '0;
      tick();
      checkIdleOutputs({tag, "_exit"});
    end
    if (saveStress !== expStress) ; // value already checked above
  endtask

  task automatic setRun(input logic [N-1:0] act, input int md, input int k, input int t,
                        input int d0, input int d1, input int d2, input int d3,
                        input logic [N-1:0] st);
    cfgAct = act;
    cfgMode = md;
    cfgK = k;
    cfgT = t;
    cfgDoneAt[0] = d0;
    cfgDoneAt[1] = d1;
    cfgDoneAt[2] = d2;
    cfgDoneAt[3] = d3;
    for (int i = 0; i < N; i++) begin
      cfgStress[i] = st[i];
      cfgDupAt[i]  = -1;
    end
    cfgResetInHold = 0;
  endtask

  // Safety net in case the design stalls the bench.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RESET          = 1'b1;
    ch_start       = '0;
    ch_done        = '0;
    ch_stress      = '0;
    mode           = '0;
    vote_k         = '0;
    timeout_cycles = '0;
    tick();
    tick();
    checkIdleOutputs("reset");
    RESET = 1'b0;
    tick();

    // OR over two channels, mixed stress.
    setRun(4'b0011, 0, 0, 0, 0, 1, -1, -1, 4'b0001);
    applyStimulus("t1_or");
    setRun(4'b0011, 0, 0, 0, 0, 1, -1, -1, 4'b0001);
    cfgResetInHold = 1;
    applyStimulus("t1_or_again");

    // AND: mixed stress gives 0, unanimous gives 1.
    setRun(4'b0011, 1, 0, 0, 2, 0, -1, -1, 4'b0001);
    applyStimulus("t2_and_mixed");
    setRun(4'b0011, 1, 0, 0, 1, 3, -1, -1, 4'b0011);
    applyStimulus("t2_and_all");
    checkOutput("t2_literal_stress", stress_out, 0);

    // K-of-N on four channels.
    setRun(4'b1111, 2, 3, 0, 0, 2, 1, 3, 4'b1011);
    applyStimulus("t3_k3");
    setRun(4'b1111, 2, 0, 0, 1, 1, 0, 2, 4'b0100);
    applyStimulus("t3_k0");
    setRun(4'b1111, 2, 5, 0, 0, 0, 0, 0, 4'b1111);
    applyStimulus("t3_k5");

    // Timeout with channel 1 silent, OR then AND.
    setRun(4'b0011, 0, 0, 5, 1, -1, -1, -1, 4'b0001);
    applyStimulus("t4_to_or");
    setRun(4'b0011, 1, 0, 5, 1, -1, -1, -1, 4'b0001);
    applyStimulus("t4_to_and");

    // Last done lands on the expiry cycle: completion wins.
    setRun(4'b0011, 1, 0, 5, 0, 5, -1, -1, 4'b0011);
    applyStimulus("t5_edge");

    // Abort mid-collect: no decision, back to idle.
    ch_start       = 4'b0011;
    mode           = 2'd0;
    vote_k         = '0;
    timeout_cycles = '0;
    tick();
    ch_done   = 4'b0001;
    ch_stress = 4'b0001;
    tick();
    ch_done = '0;
    tick();
    ch_start = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("t5_abort_valid", valid, 0);
    end
    checkIdleOutputs("t5_abort");

    // Duplicate done pulses keep the first stress value; reset in hold clears outputs.
    setRun(4'b0110, 2, 2, 0, -1, 0, 2, -1, 4'b0110);
    cfgDupAt[1] = 1;
    cfgDupAt[2] = 4;
    cfgResetInHold = 1;
    applyStimulus("t6_dup_reset");

    // Randomized runs.
    for (int r = 0; r < 30; r++) begin
      cfgAct  = 4'($urandom_range(1, 15));
      cfgMode = $urandom_range(0, 3);
      cfgK    = $urandom_range(0, 5);
      cfgT    = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(2, 10);
      for (int i = 0; i < N; i++) begin
        cfgDoneAt[i] = $urandom_range(0, 8);
        if (cfgT != 0 && $urandom_range(0, 4) == 0) cfgDoneAt[i] = -1;
        cfgStress[i] = 1'($urandom);
        cfgDupAt[i]  = (cfgDoneAt[i] >= 0) ? cfgDoneAt[i] + $urandom_range(1, 3) : -1;
      end
      cfgResetInHold = ($urandom_range(0, 4) == 0);
      applyStimulus("rand");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
